alu_mem_sequencer: RTL

- Parametrised successor to the fixed 16-bit ALU datapath system.
- Runs one memory-to-memory ALU operation on its own: reads operand A and operand B byte-by-byte from byte-wide memory, computes the result with an internal ALU, and writes the result back byte-by-byte.
- Start/Busy/Done handshake; the control FSM is internal, so no per-cycle external select lines are needed.

---
 rtl/alu_mem_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mem_sequencer.sv
// Self-sequencing memory-to-memory ALU: reads A and B byte-wise, executes one op,
// writes the result back byte-wise. States: IDLE wait | LOAD latch | RDA/RDB read | WAIT drain | EXEC alu | WR write | DONE pulse
module alu_mem_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        Op,
  input  logic [ADDR_W-1:0] SrcAAddr,
  input  logic [ADDR_W-1:0] SrcBAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic [3:0]        Flags,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_Data,
  output logic              Mem_WR,
  output logic              Mem_CS,
  input  logic [7:0]        MemOut
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RDA, S_RDB, S_WAIT, S_EXEC, S_WR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   srca_q, srca_d, srcb_q, srcb_d, dst_q, dst_d;
  logic                rd1_q, rd1_d, rd2_q, rd2_d;
  logic [2*DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0]   wsh_q, wsh_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic                busy_q, busy_d, done_q, done_d, cs_q, cs_d, wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;

  logic [DATA_W-1:0]   opa, opb, alu_res;
  logic [DATA_W:0]     sum, diff;
  logic                alu_c, alu_o;
  logic [3:0]          alu_flags;

  // Operand bytes shift in from the top, so after 2*NB captures opnd = {B, A}
  assign opa  = opnd_q[DATA_W-1:0];
  assign opb  = opnd_q[2*DATA_W-1:DATA_W];
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    alu_res = '0;
    alu_c   = flags_q[2];
    alu_o   = flags_q[0];
    case (op_q)
      3'b000: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_o   = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);
      end
      3'b001: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = ~diff[DATA_W];
        alu_o   = (opa[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != opa[DATA_W-1]);
      end
      3'b010: alu_res = opa & opb;
      3'b011: alu_res = opa | opb;
      3'b100: alu_res = opa ^ opb;
      3'b101: alu_res = ~opa;
      3'b110: begin
        alu_res = opa << 1;
        alu_c   = opa[DATA_W-1];
      end
      default: begin
        alu_res = opa >> 1;
        alu_c   = opa[0];
      end
    endcase
    alu_flags = {(alu_res == '0), alu_c, alu_res[DATA_W-1], alu_o};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    dst_d    = dst_q;
    rd2_d    = rd1_q;
    opnd_d   = opnd_q;
    wsh_d    = wsh_q;
    result_d = result_q;
    flags_d  = flags_q;
    addr_d   = addr_q;
    data_d   = data_q;

    // Read data returns two edges after the address is registered
    if (rd2_q) opnd_d = {MemOut, opnd_q[2*DATA_W-1:8]};

    case (state_q)
      S_IDLE: if (Start) begin
        state_d = S_LOAD;
        op_d    = Op;
        srca_d  = SrcAAddr;
        srcb_d  = SrcBAddr;
        dst_d   = DstAddr;
      end
      S_LOAD: begin
        state_d = S_RDA;
        cnt_d   = CNT_LAST;
        addr_d  = srca_q;
      end
      S_RDA: if (cnt_q == '0) begin
        state_d = S_RDB;
        cnt_d   = CNT_LAST;
        addr_d  = srcb_q;
      end else begin
        cnt_d  = cnt_q - CW'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
      S_RDB: if (cnt_q == '0) begin
        state_d = S_WAIT;
      end else begin
        cnt_d  = cnt_q - CW'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
      S_WAIT: state_d = S_EXEC;
      S_EXEC: begin
        state_d  = S_WR;
        cnt_d    = CNT_LAST;
        addr_d   = dst_q;
        data_d   = alu_res[7:0];
        wsh_d    = alu_res >> 8;
        result_d = alu_res;
        flags_d  = alu_flags;
      end
      S_WR: if (cnt_q == '0) begin
        state_d = S_DONE;
      end else begin
        cnt_d  = cnt_q - CW'(1);
        addr_d = addr_q + ADDR_W'(1);
        data_d = wsh_q[7:0];
        wsh_d  = wsh_q >> 8;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd1_d  = (state_d == S_RDA) || (state_d == S_RDB);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    cs_d   = (state_d == S_RDA) || (state_d == S_RDB) || (state_d == S_WR);
    wr_d   = (state_d == S_WR);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      dst_q    <= '0;
      rd1_q    <= 1'b0;
      rd2_q    <= 1'b0;
      opnd_q   <= '0;
      wsh_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      dst_q    <= dst_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      opnd_q   <= opnd_d;
      wsh_q    <= wsh_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Result      = result_q;
  assign Flags       = flags_q;
  assign Mem_Address = addr_q;
  assign Mem_Data    = data_q;
  assign Mem_WR      = wr_q;
  assign Mem_CS      = cs_q;

endmodule
